mem_mesh_router: RTL and testbench
==================================

# mem_mesh_router

Parametrised 5-port wormhole mesh router, the building block of the on-chip memory network. It replaces the fixed req/ack router with three things:
- valid/ready links per port;
- head/tail-delimited multi-flit packets (wide 256-bit SRF transfers travel as several flits);
- per-output round-robin arbitration with an S-morph priority override.

One instance sits at each mesh node. Coordinates are set by parameter. Boundary ports are tied off by the network top level.

## Interface
Port index p is 0=Local, 1=North (row-1), 2=South (row+1), 3=East (col+1), 4=West (col-1). Arrays are packed, with port p at slice p.

Parameters:
- FLIT_WIDTH, 64: flit payload bits; must be ≥ COL_BITS+ROW_BITS+1.
- BUFFER_DEPTH, 4: input FIFO entries per port; power of 2, ≥2.
- ROUTER_ROWS, 8: mesh rows. ROW_BITS = max(1, $clog2(ROUTER_ROWS)).
- ROUTER_COLS, 4: mesh cols. COL_BITS = max(1, $clog2(ROUTER_COLS)).
- MY_ROW, 0: this router's row.
- MY_COL, 0: this router's column.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  asynchronous active-low reset.
- srf_mode  in  1  S-morph SRF mode; enables priority arbitration.
- in_valid  in  5  flit offered on port p.
- in_ready  out  5  port p can accept.
- in_data  in  5*FLIT_WIDTH  incoming flits.
- in_head  in  5  first flit of packet.
- in_tail  in  5  last flit of packet; head&tail means single-flit packet.
- out_valid  out  5  flit presented on output p.
- out_ready  in  5  downstream accepts.
- out_data  out  5*FLIT_WIDTH  outgoing flits.
- out_head  out  5  forwarded head flag.
- out_tail  out  5  forwarded tail flag.
- err_orphan  out  1  one-cycle pulse: a non-head flit with no owning output was dropped.

## Operation
- **Head flit fields:**
  - dest_col = data[COL_BITS-1:0]
  - dest_row = data[COL_BITS+ROW_BITS-1:COL_BITS]
  - prio = data[FLIT_WIDTH-1]
  - Body and tail flit data is opaque.
- **Input FIFO:**
  - One per port, BUFFER_DEPTH deep.
  - Push on in_valid & in_ready.
  - in_ready = !full, computed from the registered count. A push into a full FIFO is not permitted even when a pop happens in the same cycle.
- **XY routing** (computed on the FIFO-front head flit):
  - dest_col > MY_COL → East
  - dest_col < MY_COL → West
  - otherwise dest_row > MY_ROW → South
  - dest_row < MY_ROW → North
  - otherwise Local
  - Out-of-range destinations are not checked.
- **Per-output FSM, IDLE / LOCKED(owner):**
  - **IDLE:** requesters are inputs whose FIFO front is a head flit routed to this output and whose input is not already owner elsewhere.
    - If any requester exists, select a winner, register owner, and go to LOCKED.
    - Nothing is forwarded in the grant cycle.
  - **LOCKED:**
    - out_valid[o] = owner FIFO non-empty.
    - out_data/head/tail are driven from the owner's FIFO front.
    - Pop the owner's FIFO on out_valid & out_ready.
    - A tail handshake (head&tail included) returns the FSM to IDLE. The next grant happens in the following cycle, giving a one-cycle bubble between packets.
  - Flits of different packets never interleave on one output.
- **Arbitration:**
  - Per-output RR pointer rr[o] (3 bits, range 0..4).
  - The search begins at rr[o] and proceeds upward mod 5.
  - If srf_mode=1 and any requester has prio=1, only prio requesters are searched.
  - On grant, rr[o] ← (winner+1) mod 5.
- **Orphan drop:**
  - Condition: input FIFO front is non-head and the input owns no LOCKED output.
  - Action: pop that flit the same cycle; err_orphan pulses (registered) on the next cycle.
  - Multiple orphans in one cycle produce a single pulse.
- **srf_mode:** sampled each cycle. Changing it mid-packet does not affect existing locks.

## Timing
- **Reset (async assert, sync release):**
  - FIFOs empty, all FSMs IDLE, rr=0.
  - out_valid=0, out_head=0, out_tail=0, out_data=0, err_orphan=0.
  - in_ready=0 while rst_n=0; in_ready=5'h1F from the first cycle after release.
- **Reset mid-packet:** all in-flight flits and locks are discarded. No partial packet is emitted after release.
- **Latency:** head accepted in cycle N → written N+1 → granted N+1 → out_valid in cycle N+2 (minimum 2 cycles).
- **Throughput after lock:** body flits stream at 1 flit/cycle.
- **Valid stability:** out_valid and data are held stable until out_ready, because the owner is fixed while LOCKED.
- **Simultaneous push and pop on a non-full FIFO:** count is unchanged.
- **Empty owner FIFO mid-packet:** out_valid=0 and the lock is held.

## Test plan
- **Reset:** rst_n low 3 cycles, then release → out_valid=0, err_orphan=0, in_ready=5'h1F on the first post-reset cycle.
- **Single flit, Local to East:** MY_ROW=0, MY_COL=0; head&tail on Local with dest_col=2, dest_row=0, data=64'h0123_0000_0000_0002 at cycle 0 → out_valid[3]=1 at cycle 2 with identical data; the East FSM is IDLE at cycle 3.
- **Wormhole with backpressure:**
  - Stimulus: a 4-flit packet W→S (MY 0,0; dest 0,1) with out_ready[2] low for cycles 2–4; a North→South single-flit packet arrives at cycle 1.
  - Response: West flits emerge in order A,B,C,D; the North flit follows one bubble cycle after D's handshake.
- **Round-robin:** N, S, E, W each send a single-flit packet to Local (dest = self) in the same cycle with rr=0 → Local grants in order N, S, E, W; rr ends at 0.
- **SRF priority:** East head has prio=1, North head has prio=0, both routed to Local.
  - srf_mode=1 → East forwarded first.
  - srf_mode=0 → North forwarded first.
- **Orphan and full FIFO:**
  - A lone body flit on port 1 → no out_valid; err_orphan=1 for exactly one cycle, two cycles after acceptance.
  - With out_ready=0, push 4 flits of one packet on Local → in_ready[0]=0 after the 4th push, and a 5th offered flit is not accepted.

Source files
------------

// File: rtl/mem_mesh_router_if.sv
// Link bundle for one mesh router: five valid/ready input links and five output links.
// Latency: none, wires only.
// Backpressure: in_ready is driven by the router, out_ready by the downstream node.
interface mem_mesh_router_if #(
    parameter int FLIT_WIDTH = 64
);
    logic [4:0]              in_valid;
    logic [4:0]              in_ready;
    logic [5*FLIT_WIDTH-1:0] in_data;
    logic [4:0]              in_head;
    logic [4:0]              in_tail;
    logic [4:0]              out_valid;
    logic [4:0]              out_ready;
    logic [5*FLIT_WIDTH-1:0] out_data;
    logic [4:0]              out_head;
    logic [4:0]              out_tail;

    modport slave (
        input  in_valid, in_data, in_head, in_tail, out_ready,
        output in_ready, out_valid, out_data, out_head, out_tail
    );

    modport master (
        output in_valid, in_data, in_head, in_tail, out_ready,
        input  in_ready, out_valid, out_data, out_head, out_tail
    );
endinterface

// File: rtl/mem_mesh_router.sv
// Generic FIFO used for the router input buffers.
// Latency: a pushed entry is visible at the front on the next cycle.
// Backpressure: caller must not push when full or pop when empty.
module mem_mesh_router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] front_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign front_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// 5-port XY wormhole mesh router with per-output round-robin and SRF priority override.
// Latency: head accepted in cycle N appears on its output in cycle N+2; body flits stream 1/cycle.
// Backpressure: per-port input FIFOs; in_ready drops when full, output holds flit until out_ready.
module mem_mesh_router #(
    parameter int FLIT_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 4,
    parameter int ROUTER_ROWS  = 8,
    parameter int ROUTER_COLS  = 4,
    parameter int MY_ROW       = 0,
    parameter int MY_COL       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srf_mode,
    mem_mesh_router_if.slave   lnk,
    output logic               err_orphan
);
    localparam int ROW_BITS = (ROUTER_ROWS > 1) ? $clog2(ROUTER_ROWS) : 1;
    localparam int COL_BITS = (ROUTER_COLS > 1) ? $clog2(ROUTER_COLS) : 1;
    localparam int EW       = FLIT_WIDTH + 2;

    localparam logic [ROW_BITS-1:0] MY_ROW_V = ROW_BITS'(MY_ROW);
    localparam logic [COL_BITS-1:0] MY_COL_V = COL_BITS'(MY_COL);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic                  alive;
    logic [EW-1:0]         f_ent [5];
    logic [FLIT_WIDTH-1:0] f_data [5];
    logic [4:0]            f_empty, f_full, f_head, prio;
    logic [4:0]            push, pop, orphan, owns;
    logic [2:0]            route [5];
    logic [0:0]            state [5];
    logic [2:0]            owner [5];
    logic [2:0]            rr [5];
    logic [4:0]            req [5];
    logic [4:0]            cand [5];
    logic [4:0]            grant_vld;
    logic [2:0]            grant_idx [5];
    logic [4:0]            out_valid, out_head, out_tail, tail_hs;
    logic [5*FLIT_WIDTH-1:0] out_data;

    function automatic logic [2:0] xy_route(input logic [COL_BITS+ROW_BITS-1:0] d);
        logic [COL_BITS-1:0] dc;
        logic [ROW_BITS-1:0] dr;
        dc = d[COL_BITS-1:0];
        dr = d[COL_BITS+ROW_BITS-1:COL_BITS];
        if (dc > MY_COL_V)      return 3'd3;
        else if (dc < MY_COL_V) return 3'd4;
        else if (dr > MY_ROW_V) return 3'd2;
        else if (dr < MY_ROW_V) return 3'd1;
        else                    return 3'd0;
    endfunction

    // Held low through reset so upstream sees in_ready=0 until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_in
        assign lnk.in_ready[i] = alive & ~f_full[i];
        assign push[i]         = lnk.in_valid[i] & lnk.in_ready[i];

        mem_mesh_router_fifo #(
            .WIDTH (EW),
            .DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[i]),
            .push_dat  ({lnk.in_head[i], lnk.in_tail[i], lnk.in_data[i*FLIT_WIDTH +: FLIT_WIDTH]}),
            .pop       (pop[i]),
            .front_dat (f_ent[i]),
            .empty     (f_empty[i]),
            .full      (f_full[i])
        );

        assign f_head[i] = f_ent[i][EW-1];
        assign f_data[i] = f_ent[i][FLIT_WIDTH-1:0];
        assign prio[i]   = f_ent[i][FLIT_WIDTH-1];
        assign route[i]  = xy_route(f_ent[i][COL_BITS+ROW_BITS-1:0]);
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            owns[i] = 1'b0;
            for (int o = 0; o < 5; o++) begin
                if (state[o] == ST_LOCKED && owner[o] == 3'(i)) begin
                    owns[i] = 1'b1;
                end
            end
        end
    end

    // With srf_mode, any prio head narrows the search to prio requesters only.
    always_comb begin
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                req[o][i] = !f_empty[i] && f_head[i] && !owns[i] && (route[i] == 3'(o));
            end
            cand[o]      = (srf_mode && |(req[o] & prio)) ? (req[o] & prio) : req[o];
            grant_vld[o] = 1'b0;
            grant_idx[o] = 3'd0;
            for (int k = 0; k < 5; k++) begin
                if (!grant_vld[o] && cand[o][(int'(rr[o]) + k) % 5]) begin
                    grant_vld[o] = 1'b1;
                    grant_idx[o] = 3'((int'(rr[o]) + k) % 5);
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_head  = '0;
        out_tail  = '0;
        out_data  = '0;
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                if (state[o] == ST_LOCKED && owner[o] == 3'(i) && !f_empty[i]) begin
                    out_valid[o]                         = 1'b1;
                    out_head[o]                          = f_ent[i][EW-1];
                    out_tail[o]                          = f_ent[i][EW-2];
                    out_data[o*FLIT_WIDTH +: FLIT_WIDTH] = f_data[i];
                end
            end
            tail_hs[o] = out_valid[o] & lnk.out_ready[o] & out_tail[o];
        end
    end

    // A non-head front with no locked output can never be forwarded; drop it.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            orphan[i] = !f_empty[i] && !f_head[i] && !owns[i];
            pop[i]    = orphan[i];
            for (int o = 0; o < 5; o++) begin
                if (out_valid[o] && lnk.out_ready[o] && owner[o] == 3'(i)) begin
                    pop[i] = 1'b1;
                end
            end
        end
    end

    assign lnk.out_valid = out_valid;
    assign lnk.out_head  = out_head;
    assign lnk.out_tail  = out_tail;
    assign lnk.out_data  = out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan <= 1'b0;
            for (int o = 0; o < 5; o++) begin
                state[o] <= ST_IDLE;
                owner[o] <= 3'd0;
                rr[o]    <= 3'd0;
            end
        end else begin
            err_orphan <= |orphan;
            for (int o = 0; o < 5; o++) begin
                case (state[o])
                    ST_IDLE: begin
                        if (grant_vld[o]) begin
                            state[o] <= ST_LOCKED;
                            owner[o] <= grant_idx[o];
                            rr[o]    <= (grant_idx[o] == 3'd4) ? 3'd0 : grant_idx[o] + 3'd1;
                        end
                    end
                    default: begin
                        if (tail_hs[o]) begin
                            state[o] <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_mesh_router.sv
module tb_mem_mesh_router;
    localparam int FW = 64;

    typedef struct packed {
        logic          head;
        logic          tail;
        logic [FW-1:0] data;
    } flit_t;

    logic  clk      = 1'b0;
    logic  rst_n    = 1'b1;
    logic  srf_mode = 1'b0;
    logic  err_orphan;
    int    total = 0;
    int    bad   = 0;
    flit_t exp_q [5][$];
    flit_t mon_got;
    flit_t mon_exp;

    mem_mesh_router_if #(.FLIT_WIDTH(FW)) lnk ();

    mem_mesh_router #(
        .FLIT_WIDTH   (FW),
        .BUFFER_DEPTH (4),
        .ROUTER_ROWS  (8),
        .ROUTER_COLS  (4),
        .MY_ROW       (0),
        .MY_COL       (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .srf_mode   (srf_mode),
        .lnk        (lnk),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    // Scoreboard: every output handshake must match the next expected flit for that port.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                if (lnk.out_valid[o] === 1'b1 && lnk.out_ready[o] === 1'b1) begin
                    mon_got.head = lnk.out_head[o];
                    mon_got.tail = lnk.out_tail[o];
                    mon_got.data = lnk.out_data[o*FW +: FW];
                    total++;
                    if (exp_q[o].size() == 0) begin
                        bad++;
                        $display("FAIL out_flit port=%0d got h=%0b t=%0b d=%h want none", o, mon_got.head, mon_got.tail, mon_got.data);
                    end else begin
                        mon_exp = exp_q[o].pop_front();
                        if (mon_got !== mon_exp) begin
                            bad++;
                            $display("FAIL out_flit port=%0d got h=%0b t=%0b d=%h want h=%0b t=%0b d=%h", o,
                                     mon_got.head, mon_got.tail, mon_got.data, mon_exp.head, mon_exp.tail, mon_exp.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input int p, input logic h, input logic t, input logic [FW-1:0] d);
        lnk.in_valid[p]         = 1'b1;
        lnk.in_head[p]          = h;
        lnk.in_tail[p]          = t;
        lnk.in_data[p*FW +: FW] = d;
    endtask

    task automatic push_exp(input int o, input logic h, input logic t, input logic [FW-1:0] d);
        flit_t f;
        f.head = h;
        f.tail = t;
        f.data = d;
        exp_q[o].push_back(f);
    endtask

    task automatic idle_inputs();
        lnk.in_valid  = '0;
        lnk.in_head   = '0;
        lnk.in_tail   = '0;
        lnk.in_data   = '0;
        lnk.out_ready = '1;
        srf_mode      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int o = 0; o < 5; o++) exp_q[o].delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (lnk.in_ready !== 5'h00) begin bad++; $display("FAIL rst_in_ready got=%h want=00", lnk.in_ready); end
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL rst_out_valid got=%h want=00", lnk.out_valid); end
        total++; if (lnk.out_data !== '0 || lnk.out_head !== 5'h00 || lnk.out_tail !== 5'h00) begin
            bad++; $display("FAIL rst_out_flags got head=%h tail=%h want 00", lnk.out_head, lnk.out_tail);
        end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_orphan); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        @(negedge clk);
        total++; if (lnk.in_ready !== 5'h1F) begin bad++; $display("FAIL post_rst_in_ready got=%h want=1f", lnk.in_ready); end
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL post_rst_out_valid got=%h want=00", lnk.out_valid); end
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%b want=0", err_orphan); end
    endtask

    task automatic test_single_flit();
        logic [FW-1:0] d;
        d = 64'h0123_0000_0000_0002;
        do_reset();
        tick();
        drive(0, 1'b1, 1'b1, d);
        push_exp(3, 1'b1, 1'b1, d);
        @(negedge clk);
        total++; if (lnk.in_ready[0] !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", lnk.in_ready[0]); end
        tick();
        lnk.in_valid = '0;
        @(negedge clk);
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL single_c1_valid got=%h want=00", lnk.out_valid); end
        tick();
        @(negedge clk);
        total++; if (lnk.out_valid !== 5'h08) begin bad++; $display("FAIL single_c2_valid got=%h want=08", lnk.out_valid); end
        tick();
        @(negedge clk);
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL single_c3_valid got=%h want=00", lnk.out_valid); end
        total++; if (exp_q[3].size() != 0) begin bad++; $display("FAIL single_drain left=%0d want=0", exp_q[3].size()); end
    endtask

    task automatic test_wormhole();
        logic [FW-1:0] wd [4];
        logic [FW-1:0] nd;
        int d_cyc;
        int x_cyc;
        d_cyc = -1;
        x_cyc = -1;
        wd[0] = 64'hA000_0000_0000_0004;
        wd[1] = 64'hB111_2222_3333_4444;
        wd[2] = 64'hC555_6666_7777_8888;
        wd[3] = 64'hD999_AAAA_BBBB_CCCC;
        nd    = 64'h5555_0000_0000_0004;
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) push_exp(2, k == 0, k == 3, wd[k]);
        push_exp(2, 1'b1, 1'b1, nd);
        for (int c = 0; c < 20; c++) begin
            lnk.in_valid = '0;
            if (c < 4) drive(4, c == 0, c == 3, wd[c]);
            if (c == 1) drive(1, 1'b1, 1'b1, nd);
            lnk.out_ready[2] = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c < 4) begin
                total++; if (lnk.in_ready[4] !== 1'b1) begin bad++; $display("FAIL worm_accept c=%0d got=%b want=1", c, lnk.in_ready[4]); end
            end
            if (c == 3) begin
                total++;
                if (lnk.out_valid[2] !== 1'b1 || lnk.out_data[2*FW +: FW] !== wd[0]) begin
                    bad++; $display("FAIL worm_stall_hold got v=%b d=%h want v=1 d=%h", lnk.out_valid[2], lnk.out_data[2*FW +: FW], wd[0]);
                end
            end
            if (lnk.out_valid[2] === 1'b1 && lnk.out_ready[2] === 1'b1) begin
                if (lnk.out_data[2*FW +: FW] === wd[3]) d_cyc = c;
                if (lnk.out_data[2*FW +: FW] === nd)    x_cyc = c;
            end
            tick();
        end
        lnk.in_valid = '0;
        total++; if (d_cyc < 0 || x_cyc != d_cyc + 2) begin bad++; $display("FAIL worm_bubble got d=%0d x=%0d want x=d+2", d_cyc, x_cyc); end
        total++; if (exp_q[2].size() != 0) begin bad++; $display("FAIL worm_drain left=%0d want=0", exp_q[2].size()); end
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] d;
        do_reset();
        tick();
        for (int p = 1; p < 5; p++) begin
            d = 64'(p) << 40;
            drive(p, 1'b1, 1'b1, d);
            push_exp(0, 1'b1, 1'b1, d);
        end
        @(negedge clk);
        total++; if (lnk.in_ready !== 5'h1F) begin bad++; $display("FAIL rr_accept got=%h want=1f", lnk.in_ready); end
        tick();
        lnk.in_valid = '0;
        run(12);
        total++; if (exp_q[0].size() != 0) begin bad++; $display("FAIL rr_drain left=%0d want=0", exp_q[0].size()); end
        // Pointer wrapped back to 0, so North beats West on a simultaneous request.
        drive(1, 1'b1, 1'b1, 64'h0000_0011_0000_0000);
        drive(4, 1'b1, 1'b1, 64'h0000_0044_0000_0000);
        push_exp(0, 1'b1, 1'b1, 64'h0000_0011_0000_0000);
        push_exp(0, 1'b1, 1'b1, 64'h0000_0044_0000_0000);
        tick();
        lnk.in_valid = '0;
        run(8);
        total++; if (exp_q[0].size() != 0) begin bad++; $display("FAIL rr_wrap_drain left=%0d want=0", exp_q[0].size()); end
    endtask

    task automatic test_srf_prio();
        logic [FW-1:0] ed;
        logic [FW-1:0] nd;
        ed = 64'h8000_0000_0000_EE00;
        nd = 64'h0000_0000_0000_1100;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            tick();
            srf_mode = (pass == 0);
            if (pass == 0) begin
                push_exp(0, 1'b1, 1'b1, ed);
                push_exp(0, 1'b1, 1'b1, nd);
            end else begin
                push_exp(0, 1'b1, 1'b1, nd);
                push_exp(0, 1'b1, 1'b1, ed);
            end
            drive(3, 1'b1, 1'b1, ed);
            drive(1, 1'b1, 1'b1, nd);
            tick();
            lnk.in_valid = '0;
            run(8);
            total++; if (exp_q[0].size() != 0) begin bad++; $display("FAIL srf_drain srf=%0d left=%0d want=0", srf_mode, exp_q[0].size()); end
        end
    endtask

    task automatic test_orphan();
        do_reset();
        tick();
        drive(1, 1'b0, 1'b0, 64'h0BAD_0000_0000_0003);
        @(negedge clk);
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_c0 got=%b want=0", err_orphan); end
        tick();
        lnk.in_valid = '0;
        @(negedge clk);
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_c1 got=%b want=0", err_orphan); end
        tick();
        @(negedge clk);
        total++; if (err_orphan !== 1'b1) begin bad++; $display("FAIL orphan_c2 got=%b want=1", err_orphan); end
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL orphan_valid got=%h want=00", lnk.out_valid); end
        tick();
        @(negedge clk);
        total++; if (err_orphan !== 1'b0) begin bad++; $display("FAIL orphan_c3 got=%b want=0", err_orphan); end
    endtask

    task automatic test_full_fifo();
        logic [FW-1:0] fd [4];
        fd[0] = 64'hF000_0000_0000_0001;
        fd[1] = 64'hF111_1111_1111_1111;
        fd[2] = 64'hF222_2222_2222_2222;
        fd[3] = 64'hF333_3333_3333_3333;
        do_reset();
        tick();
        lnk.out_ready = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                drive(0, c == 0, c == 3, fd[c]);
                push_exp(3, c == 0, c == 3, fd[c]);
            end else begin
                drive(0, 1'b1, 1'b1, 64'hDEAD_0000_0000_0001);
            end
            @(negedge clk);
            total++;
            if (lnk.in_ready[0] !== (c < 4)) begin
                bad++; $display("FAIL full_in_ready c=%0d got=%b want=%b", c, lnk.in_ready[0], c < 4);
            end
            tick();
        end
        lnk.in_valid  = '0;
        lnk.out_ready = '1;
        run(12);
        total++; if (exp_q[3].size() != 0) begin bad++; $display("FAIL full_drain left=%0d want=0", exp_q[3].size()); end
        @(negedge clk);
        total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL full_extra got=%h want=00", lnk.out_valid); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        tick();
        lnk.out_ready[3] = 1'b0;
        drive(0, 1'b1, 1'b0, 64'h7000_0000_0000_0001);
        tick();
        lnk.in_valid = '0;
        tick();
        @(negedge clk);
        total++; if (lnk.out_valid !== 5'h08) begin bad++; $display("FAIL midrst_locked got=%h want=08", lnk.out_valid); end
        tick();
        rst_n         = 1'b0;
        lnk.out_ready = '1;
        run(2);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (lnk.out_valid !== 5'h00) begin bad++; $display("FAIL midrst_quiet c=%0d got=%h want=00", c, lnk.out_valid); end
            tick();
        end
        @(negedge clk);
        total++; if (lnk.in_ready !== 5'h1F) begin bad++; $display("FAIL midrst_in_ready got=%h want=1f", lnk.in_ready); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_flit();
        test_wormhole();
        test_round_robin();
        test_srf_prio();
        test_orphan();
        test_full_fifo();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
